// File: rtl/prog_loader.sv
// Program loader: assembles a host byte stream into 35-bit instructions and
// writes them into a program RAM that the CPU fetch unit reads combinationally.
module prog_loader #(
    parameter int AW = 8,
    parameter int IW = 35,
    parameter int NB = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [IW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   wr_count
);

    typedef enum logic [1:0] {IDLE, COUNT, BYTES, DONE} state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [AW-1:0] wr_addr_r;
    logic [AW:0]   wr_count_r;
    logic [AW:0]   count_inc_s;
    logic [AW:0]   target_s;
    logic [7:0]    n_r;
    logic [2:0]    byte_idx_r;
    logic [IW-9:0] asm_r;
    logic          busy_r;
    logic          done_r;
    logic          active_s;
    logic          restart_s;
    logic          accept_s;
    logic          last_byte_s;
    logic [IW-1:0] mem_r [0:(1<<AW)-1];

    // Handshake and write-strobe decode; start pre-empts any byte on offer
    always_comb begin
        active_s    = (state_r == COUNT) || (state_r == BYTES);
        restart_s   = start && (state_r != DONE);
        in_ready    = active_s && !start;
        accept_s    = in_valid && in_ready;
        last_byte_s = (state_r == BYTES) && accept_s && (byte_idx_r == 3'(NB - 1));
        count_inc_s = wr_count_r + {{AW{1'b0}}, 1'b1};
        if (n_r == 8'd0) begin
            target_s = {1'b1, {AW{1'b0}}};
        end else begin
            target_s = {{(AW - 7){1'b0}}, n_r};
        end
    end

    // Next-state logic; a zero word count means a full 2^AW-word session
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = COUNT;
                else       state_next_s = IDLE;
            end
            COUNT: begin
                if (start)         state_next_s = COUNT;
                else if (accept_s) state_next_s = BYTES;
                else               state_next_s = COUNT;
            end
            BYTES: begin
                if (start)                                        state_next_s = COUNT;
                else if (last_byte_s && (count_inc_s == target_s)) state_next_s = DONE;
                else                                              state_next_s = BYTES;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Session counters and MSB-first assembly; byte 0's high bits shift out the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_r  <= {AW{1'b0}};
            wr_count_r <= {(AW + 1){1'b0}};
            n_r        <= 8'd0;
            byte_idx_r <= 3'd0;
            asm_r      <= {(IW - 8){1'b0}};
        end else if (restart_s) begin
            wr_addr_r  <= {AW{1'b0}};
            wr_count_r <= {(AW + 1){1'b0}};
            byte_idx_r <= 3'd0;
            asm_r      <= {(IW - 8){1'b0}};
        end else if (accept_s) begin
            case (state_r)
                COUNT: n_r <= in_data;
                BYTES: begin
                    asm_r <= {asm_r[IW-17:0], in_data};
                    if (last_byte_s) begin
                        byte_idx_r <= 3'd0;
                        wr_addr_r  <= wr_addr_r + {{(AW - 1){1'b0}}, 1'b1};
                        wr_count_r <= count_inc_s;
                    end else begin
                        byte_idx_r <= byte_idx_r + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Program RAM write port; contents deliberately survive rst
    always_ff @(posedge clk) begin
        if (last_byte_s) begin
            mem_r[wr_addr_r] <= {asm_r, in_data};
        end
    end

    assign rd_data  = mem_r[rd_addr];
    assign busy     = busy_r;
    assign done     = done_r;
    assign wr_count = wr_count_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a scoreboard queue holds each expected
// RAM write and is drained as the write becomes visible on rd_data.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  rd_addr = 8'd0;
    logic [34:0] rd_data;
    logic        busy;
    logic        done;
    logic [8:0]  wr_count;

    typedef struct {
        logic [7:0]  addr;
        logic [34:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [34:0] exp_mem [0:255];
    logic [7:0]  exp_addr = 8'd0;
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;

    prog_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Count cycles during which done is high
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        bit ok;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else    check("ready_timeout", 64'd0, 64'd1);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [39:0] bytes, input int maxgap);
        exp_t e;
        e.addr = exp_addr;
        e.data = bytes[34:0];
        sb_q.push_back(e);
        exp_mem[exp_addr] = bytes[34:0];
        exp_addr = exp_addr + 8'd1;
        for (int k = 4; k >= 0; k--) send_byte(bytes[k*8 +: 8], maxgap);
        e = sb_q.pop_front();
        rd_addr = e.addr;
        #1 check("word_write", {29'd0, rd_data}, {29'd0, e.data});
    endtask

    task automatic start_session();
        @(negedge clk);
        start = 1'b1;
        exp_addr = 8'd0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                check("ready_in_done", {63'd0, in_ready}, 64'd0);
                break;
            end
        end
        check("done_seen", {63'd0, got}, 64'd1);
        @(negedge clk);
        check("busy_after", {63'd0, busy}, 64'd0);
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [34:0] exp);
        rd_addr = a;
        #1 check(tag, {29'd0, rd_data}, {29'd0, exp});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = 35'd0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {63'd0, in_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_count", {55'd0, wr_count}, 64'd0);
        rst = 1'b0;

        // IDLE refuses bytes
        @(negedge clk);
        in_data = 8'h55;
        in_valid = 1'b1;
        check("idle_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;

        // basic three-word load
        start_session();
        check("count_busy", {63'd0, busy}, 64'd1);
        send_byte(8'h03, 0);
        send_word(40'h00_00_00_00_0A, 0);
        send_word(40'h05_12_34_56_78, 0);
        send_word(40'h07_FF_FF_FF_FF, 0);
        wait_done();
        check("t1_count", {55'd0, wr_count}, 64'd3);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        read_check("t1_ram1", 8'd1, 35'h5_1234_5678);

        // same stream with random gaps, different data in word 0 first
        start_session();
        send_byte(8'h01, 0);
        send_word(40'h00_DE_AD_BE_EF, 0);
        wait_done();
        start_session();
        send_byte(8'h03, 3);
        send_word(40'h00_00_00_00_0A, 3);
        send_word(40'h05_12_34_56_78, 3);
        send_word(40'h07_FF_FF_FF_FF, 3);
        wait_done();
        check("t2_count", {55'd0, wr_count}, 64'd3);
        check("t2_done_cnt", 64'(done_cnt), 64'd3);
        read_check("t2_ram0", 8'd0, 35'h0_0000_000A);
        read_check("t2_ram2", 8'd2, 35'h7_FFFF_FFFF);

        // upper bits of byte 0 ignored
        start_session();
        send_byte(8'h01, 0);
        send_word(40'hFD_01_02_03_04, 0);
        wait_done();
        read_check("t3_top", 8'd0, 35'h5_0102_0304);

        // N=0: full 256-word session
        start_session();
        send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            send_word({8'(i), 32'(i) * 32'h9E37_79B1}, 0);
            if (i == 254) check("t4_not_done", {63'd0, done}, 64'd0);
        end
        wait_done();
        check("t4_count", {55'd0, wr_count}, 64'd256);
        check("t4_done_cnt", 64'(done_cnt), 64'd5);
        read_check("t4_ram255", 8'd255, exp_mem[255]);
        read_check("t4_ram0", 8'd0, exp_mem[0]);

        // mid-word restart
        start_session();
        send_byte(8'h02, 0);
        send_word(40'h03_11_11_11_11, 0);
        send_byte(8'h06, 0);
        send_byte(8'h22, 0);
        start_session();
        send_byte(8'h01, 0);
        send_word(40'h02_AB_CD_EF_01, 0);
        wait_done();
        check("t5_count", {55'd0, wr_count}, 64'd1);
        read_check("t5_ram0", 8'd0, 35'h2_ABCD_EF01);
        read_check("t5_ram1", 8'd1, exp_mem[1]);

        // asynchronous reset mid-BYTES
        start_session();
        send_byte(8'h03, 0);
        send_word(40'h01_CA_FE_F0_0D, 0);
        send_byte(8'h04, 0);
        send_byte(8'h33, 0);
        #2 rst = 1'b1;
        #1 check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_ready", {63'd0, in_ready}, 64'd0);
        check("t6_count", {55'd0, wr_count}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        read_check("t6_ram0_kept", 8'd0, 35'h1_CAFE_F00D);
        start_session();
        send_byte(8'h01, 0);
        send_word(40'h06_01_23_45_67, 0);
        wait_done();
        check("t6_restart_count", {55'd0, wr_count}, 64'd1);
        read_check("t6_ram1_kept", 8'd1, exp_mem[1]);
        check("t6_done_cnt", 64'(done_cnt), 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
